// File: rtl/pipe_grf_if.sv
// Bus bundle for pipe_grf: write, claim, read and clear signals.
// The master drives requests and the slave (the register file) drives read data and status.
interface pipe_grf_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              claim;
  logic [ADDR_W-1:0] ca;
  logic              pend1;
  logic              pend2;
  logic              clr;
  logic              busy;

  modport master (
    output we, wa, wd, ra1, ra2, claim, ca, clr,
    input  rd1, rd2, pend1, pend2, busy
  );

  modport slave (
    input  we, wa, wd, ra1, ra2, claim, ca, clr,
    output rd1, rd2, pend1, pend2, busy
  );
endinterface

// File: rtl/pipe_grf.sv
// Pipeline register file with per-register pending (scoreboard) bits and a sequenced clear.
// Optional write-through forwarding is enabled by defining GRF_BYPASS_EN.
module pipe_grf #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic       clk,
  input  logic       reset,
  pipe_grf_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;

  logic wr_act;
  logic clm_act;

  assign wr_act  = bus.we    && (bus.wa != '0) && (state_q == ST_IDLE);
  assign clm_act = bus.claim && (bus.ca != '0) && (state_q == ST_IDLE);
  assign bus.busy = (state_q == ST_CLEAR);

  // Next-state: register/pending updates, clear sequencing.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    regs_d  = regs_q;
    pend_d  = pend_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_act) begin
          regs_d[bus.wa] = bus.wd;
          pend_d[bus.wa] = 1'b0;
        end else begin
          pend_d = pend_q;
        end
        // Claim is applied after the write so a same-address claim keeps the bit set.
        if (clm_act) begin
          pend_d[bus.ca] = 1'b1;
        end else begin
          pend_d = pend_d;
        end
        if (bus.clr) begin
          state_d = ST_CLEAR;
          ptr_d   = ADDR_W'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        regs_d[ptr_q] = '0;
        pend_d[ptr_q] = 1'b0;
        if (ptr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d   = ptr_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // State, pointer, register array and pending bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      pend_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
      regs_q  <= regs_d;
    end
  end

  // Combinational read ports; everything reads zero while clearing.
  always_comb begin
    bus.rd1   = '0;
    bus.rd2   = '0;
    bus.pend1 = 1'b0;
    bus.pend2 = 1'b0;
    if (state_q == ST_IDLE) begin
      bus.rd1   = regs_q[bus.ra1];
      bus.rd2   = regs_q[bus.ra2];
      bus.pend1 = pend_q[bus.ra1];
      bus.pend2 = pend_q[bus.ra2];
`ifdef GRF_BYPASS_EN
      if (wr_act && (bus.ra1 == bus.wa)) begin
        bus.rd1   = bus.wd;
        bus.pend1 = clm_act && (bus.ca == bus.wa);
      end else begin
        bus.rd1   = regs_q[bus.ra1];
      end
      if (wr_act && (bus.ra2 == bus.wa)) begin
        bus.rd2   = bus.wd;
        bus.pend2 = clm_act && (bus.ca == bus.wa);
      end else begin
        bus.rd2   = regs_q[bus.ra2];
      end
`else
      bus.rd1 = regs_q[bus.ra1];
      bus.rd2 = regs_q[bus.ra2];
`endif
    end else begin
      bus.rd1   = '0;
      bus.rd2   = '0;
      bus.pend1 = 1'b0;
      bus.pend2 = 1'b0;
    end
  end
endmodule

// File: tb/tb_pipe_grf.sv
// Self-checking bench for pipe_grf: reference model with per-cycle compare plus directed literal checks.
module tb_pipe_grf;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  pipe_grf_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  pipe_grf #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: contents, pending set, and how far a running clear has progressed.
  logic [DW-1:0] mreg [DEPTH];
  bit            mpend [DEPTH];
  bit            mbusy;
  int            clr_k;

  task automatic model_zero();
    for (int i = 0; i < DEPTH; i++) begin
      mreg[i]  = '0;
      mpend[i] = 1'b0;
    end
    mbusy = 1'b0;
    clr_k = 0;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_zero();
    end else if (mbusy) begin
      clr_k++;
      mreg[clr_k]  = '0;
      mpend[clr_k] = 1'b0;
      if (clr_k == DEPTH - 1) mbusy = 1'b0;
    end else begin
      if (bus.we && bus.wa != 0) begin
        mreg[bus.wa]  = bus.wd;
        mpend[bus.wa] = 1'b0;
      end
      if (bus.claim && bus.ca != 0) mpend[bus.ca] = 1'b1;
      if (bus.clr) begin
        mbusy = 1'b1;
        clr_k = 0;
      end
    end
  end

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (mbusy || !reset) return '0;
`ifdef GRF_BYPASS_EN
    if (bus.we && bus.wa != 0 && a == bus.wa) return bus.wd;
`endif
    return mreg[a];
  endfunction

  function automatic logic exp_pend(input logic [AW-1:0] a);
    if (mbusy || !reset || a == 0) return 1'b0;
`ifdef GRF_BYPASS_EN
    if (bus.we && bus.wa != 0 && a == bus.wa) return bus.claim && (bus.ca == bus.wa);
`endif
    return mpend[a];
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    chk("model_rd1",   bus.rd1,          exp_rd(bus.ra1));
    chk("model_rd2",   bus.rd2,          exp_rd(bus.ra2));
    chk("model_pend1", 32'(bus.pend1),   32'(exp_pend(bus.ra1)));
    chk("model_pend2", 32'(bus.pend2),   32'(exp_pend(bus.ra2)));
    chk("model_busy",  32'(bus.busy),    32'(mbusy));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.we    = 1'b0;
    bus.claim = 1'b0;
    bus.clr   = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.we = 1'b1;
    bus.wa = a;
    bus.wd = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    model_zero();
    reset     = 1'b0;
    bus.we    = 1'b0;
    bus.wa    = '0;
    bus.wd    = '0;
    bus.ra1   = '0;
    bus.ra2   = '0;
    bus.claim = 1'b0;
    bus.ca    = '0;
    bus.clr   = 1'b0;
    step();
    step();
    bus.ra1 = 5'd5;
    #1;
    chk("reset_rd1",  bus.rd1, 32'h0);
    chk("reset_busy", 32'(bus.busy), 32'h0);
    reset = 1'b1;
    step();

    // Write then read back; register 0 ignores writes.
    wr(5'd5, 32'h1234_5678);
    bus.ra1 = 5'd5;
    step();
    quiet();
    #1;
    chk("w5_rd1", bus.rd1, 32'h1234_5678);
    wr(5'd0, 32'hFFFF_FFFF);
    bus.ra1 = 5'd0;
    step();
    quiet();
    #1;
    chk("w0_rd1", bus.rd1, 32'h0);

    // Same-cycle write/read of address 7.
    wr(5'd7, 32'hA5A5_A5A5);
    bus.ra2 = 5'd7;
    #1;
`ifdef GRF_BYPASS_EN
    chk("bypass_rd2", bus.rd2, 32'hA5A5_A5A5);
`else
    chk("nobypass_rd2", bus.rd2, 32'h0);
`endif
    step();
    quiet();
    #1;
    chk("after_w7_rd2", bus.rd2, 32'hA5A5_A5A5);

    // Pending bits: claim, claim-wins, write clears, independent addresses, address 0.
    bus.claim = 1'b1;
    bus.ca    = 5'd3;
    bus.ra1   = 5'd3;
    step();
    quiet();
    #1;
    chk("claim3_pend1", 32'(bus.pend1), 32'h1);
    wr(5'd3, 32'h0000_0033);
    bus.claim = 1'b1;
    bus.ca    = 5'd3;
    step();
    quiet();
    #1;
    chk("claim_wins_pend1", 32'(bus.pend1), 32'h1);
    wr(5'd3, 32'h0000_0034);
    step();
    quiet();
    #1;
    chk("write_clr_pend1", 32'(bus.pend1), 32'h0);
    wr(5'd6, 32'h0000_0066);
    bus.claim = 1'b1;
    bus.ca    = 5'd4;
    bus.ra1   = 5'd4;
    bus.ra2   = 5'd6;
    step();
    quiet();
    bus.claim = 1'b1;
    bus.ca    = 5'd0;
    #1;
    chk("diff_pend1_4", 32'(bus.pend1), 32'h1);
    chk("diff_pend2_6", 32'(bus.pend2), 32'h0);
    chk("diff_rd2_6",   bus.rd2,        32'h0000_0066);
    step();
    quiet();
    bus.ra1 = 5'd0;
    #1;
    chk("claim0_pend1", 32'(bus.pend1), 32'h0);

    // Fill every register, then run a full clear with writes/claims/clr held high throughout.
    for (int i = 1; i < DEPTH; i++) begin
      wr(AW'(i), 32'h0101_0101 * i);
      step();
    end
    quiet();
    bus.ra1 = 5'd31;
    bus.ra2 = 5'd1;
    #1;
    chk("fill_rd31", bus.rd1, 32'h1F1F_1F1F);
    bus.clr = 1'b1;
    step();
    wr(5'd10, 32'h0000_DEAD);
    bus.claim = 1'b1;
    bus.ca    = 5'd2;
    bus.ra1   = 5'd5;
    #1;
    chk("clear_rd1_zero", bus.rd1, 32'h0);
    cnt = 0;
    while (bus.busy && cnt < 40) begin
      cnt++;
      step();
    end
    quiet();
    chk("busy_cycles", 32'(cnt), 32'd31);
    for (int i = 0; i < DEPTH; i++) begin
      bus.ra1 = AW'(i);
      bus.ra2 = AW'(i);
      #1;
      chk("post_clear_rd1",   bus.rd1,          32'h0);
      chk("post_clear_pend2", 32'(bus.pend2),   32'h0);
    end

    // Reset in the middle of a clear.
    wr(5'd12, 32'h0000_0C0C);
    step();
    quiet();
    bus.clr = 1'b1;
    step();
    quiet();
    for (int i = 0; i < 9; i++) step();
    bus.ra1 = 5'd12;
    reset = 1'b0;
    #1;
    chk("midclr_reset_busy", 32'(bus.busy), 32'h0);
    chk("midclr_reset_rd1",  bus.rd1,       32'h0);
    step();
    reset = 1'b1;
    wr(5'd9, 32'h0000_0001);
    bus.ra1 = 5'd9;
    step();
    quiet();
    #1;
    chk("post_reset_w9", bus.rd1, 32'h0000_0001);
    chk("post_reset_busy", 32'(bus.busy), 32'h0);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
